sd_fifo_head_c: RTL

SD_FIFO_HEAD_C -- requirements
Module: sd_fifo_head_c

---
 rtl/sd_fifo_head_c.sv | 102 ++++++++++
 1 files changed

// File: rtl/sd_fifo_head_c.sv
// Write-side head of a split FIFO: owns the write pointer, full/usage/afull, and the memory write strobe.
// Zero-latency accept (wr_en same cycle); c_drdy drops when full. Commit/abort option: SD_FIFO_HEAD_COMMIT_EN.
module sd_fifo_head_c #(
   parameter int depth     = 16,
   parameter int async     = 0,
   parameter int asz       = $clog2(depth),
   parameter int afull_lvl = depth - 2
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           clken,
   input  logic           c_srdy,
   output logic           c_drdy,
`ifdef SD_FIFO_HEAD_COMMIT_EN
   input  logic           c_commit,
   input  logic           c_abort,
`endif
   output logic           wr_en,
   output logic [asz-1:0] wr_addr,
   output logic [asz:0]   wrptr_head,
   input  logic [asz:0]   rdptr_tail,
   output logic [asz:0]   c_usage,
   output logic           c_afull
);

   localparam logic [asz:0] afull_thr = (asz+1)'(afull_lvl);

   function automatic logic [asz:0] gray2bin(input logic [asz:0] g);
      logic [asz:0] b;
      b[asz] = g[asz];
      for (int i = asz - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [asz:0] bin2gray(input logic [asz:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [asz:0] r_wrptr;
   logic [asz:0] r_head_g;
   logic [asz:0] w_wrptr_nxt;
   logic [asz:0] w_rdptr;
   logic [asz:0] w_head_cur;
   logic [asz:0] w_head_nxt;
   logic         w_full;

   assign w_rdptr = (async != 0) ? gray2bin(rdptr_tail) : rdptr_tail;

   // Same low bits with differing wrap bits means the writer is a full lap ahead.
   assign w_full  = (r_wrptr[asz] != w_rdptr[asz]) &&
                    (r_wrptr[asz-1:0] == w_rdptr[asz-1:0]);
   assign c_drdy  = ~w_full;
   assign wr_en   = clken & c_srdy & c_drdy;
   assign wr_addr = r_wrptr[asz-1:0];
   assign c_usage = r_wrptr - w_rdptr;
   assign c_afull = (c_usage >= afull_thr);

`ifdef SD_FIFO_HEAD_COMMIT_EN
   logic [asz:0] r_cptr;
   logic [asz:0] w_cptr_nxt;

   // Abort rewinds to the last commit and wins over a simultaneous commit.
   always_comb begin
      w_wrptr_nxt = r_wrptr + {{asz{1'b0}}, wr_en};
      w_cptr_nxt  = r_cptr;
      if (c_abort)
         w_wrptr_nxt = r_cptr;
      else if (c_commit)
         w_cptr_nxt = w_wrptr_nxt;
   end

   assign w_head_cur = r_cptr;
   assign w_head_nxt = w_cptr_nxt;
`else
   always_comb begin
      w_wrptr_nxt = r_wrptr + {{asz{1'b0}}, wr_en};
   end

   assign w_head_cur = r_wrptr;
   assign w_head_nxt = w_wrptr_nxt;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wrptr  <= '0;
         r_head_g <= '0;
`ifdef SD_FIFO_HEAD_COMMIT_EN
         r_cptr   <= '0;
`endif
      end else if (clken) begin
         r_wrptr  <= w_wrptr_nxt;
         r_head_g <= bin2gray(w_head_nxt);
`ifdef SD_FIFO_HEAD_COMMIT_EN
         r_cptr   <= w_cptr_nxt;
`endif
      end
   end

   // Crossing clocks needs a glitch-free registered Gray value; same-clock uses the pointer directly.
   assign wrptr_head = (async != 0) ? r_head_g : w_head_cur;

endmodule
